// File: rtl/load_store_unit_if.sv
// Request/writeback and data-memory bus bundle for load_store_unit.
// master = the LSU itself, slave = requester plus memory side.
interface load_store_unit_if;
  logic        lsu_valid;
  logic        lsu_load;
  logic [2:0]  lsu_func3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        lsu_busy;
  logic        lsu_done;
  logic [1:0]  lsu_error;
  logic        load_we;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    input  lsu_valid, lsu_load, lsu_func3,
    input  lsu_addr, lsu_wdata, lsu_rd,
    output lsu_busy, lsu_done, lsu_error,
    output load_we, load_rd, load_data,
    output mem_req, mem_we, mem_addr,
    output mem_wstrb, mem_wdata,
    input  mem_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    output lsu_valid, lsu_load, lsu_func3,
    output lsu_addr, lsu_wdata, lsu_rd,
    input  lsu_busy, lsu_done, lsu_error,
    input  load_we, load_rd, load_data,
    input  mem_req, mem_we, mem_addr,
    input  mem_wstrb, mem_wdata,
    output mem_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: single-outstanding load/store bus master with
// lane alignment, load extension and misalign/func3/timeout errors.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clock,
  input logic reset,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_TO = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] E_OK = 2'b00;
  localparam logic [1:0] E_MIS = 2'b01;
  localparam logic [1:0] E_F3 = 2'b10;
  localparam logic [1:0] E_TO = 2'b11;

  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] err_q, err_d;

  logic c_load;
  logic [2:0] c_func3;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [4:0] c_rd;
  logic [4:0] rd_q;
  logic [31:0] data_q;

  logic take;
  logic fin_early;
  logic fin_bus;
  logic rsp_ok;

  logic illegal;
  logic misal;
  logic to_hit;
  logic [1:0] off;
  logic [31:0] shifted;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;
  logic [3:0] strb;
  logic [31:0] wdat;

  always_comb begin
    illegal = 1'b0;
    misal = 1'b0;
    unique case (1'b1)
      bus.lsu_func3 == 3'b000: illegal = 1'b0;
      bus.lsu_func3 == 3'b001: illegal = 1'b0;
      bus.lsu_func3 == 3'b010: illegal = 1'b0;
      bus.lsu_func3 == 3'b100: illegal = !bus.lsu_load;
      bus.lsu_func3 == 3'b101: illegal = !bus.lsu_load;
      default: illegal = 1'b1;
    endcase
    if (bus.lsu_func3[1:0] == 2'b01)
      misal = bus.lsu_addr[0];
    else if (bus.lsu_func3[1:0] == 2'b10)
      misal = |bus.lsu_addr[1:0];
  end

  assign to_hit = (cnt >= CNT_TO);

  always_comb begin
    state_d = state;
    cnt_d = cnt;
    err_d = err_q;
    take = 1'b0;
    fin_early = 1'b0;
    fin_bus = 1'b0;
    rsp_ok = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.lsu_valid) begin
          take = 1'b1;
          if (illegal) begin
            err_d = E_F3;
            state_d = DONE;
            fin_early = 1'b1;
          end else if (misal) begin
            err_d = E_MIS;
            state_d = DONE;
            fin_early = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d = '0;
          end
        end
      end
      REQ: begin
        cnt_d = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        if (bus.mem_ready) begin
          state_d = WAIT;
        end else if (to_hit) begin
          err_d = E_TO;
          state_d = DONE;
          fin_bus = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        // a response in the timeout cycle still completes normally
        if (bus.mem_rsp_valid) begin
          err_d = E_OK;
          state_d = DONE;
          fin_bus = 1'b1;
          rsp_ok = 1'b1;
        end else if (to_hit) begin
          err_d = E_TO;
          state_d = DONE;
          fin_bus = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign off = c_addr[1:0];
  assign shifted = bus.mem_rdata >> {off, 3'b000};
  assign rbyte = shifted[7:0];
  assign rhalf = off[1] ? bus.mem_rdata[31:16]
                        : bus.mem_rdata[15:0];

  always_comb begin
    ext = bus.mem_rdata;
    unique case (1'b1)
      c_func3 == 3'b000: ext = {{24{rbyte[7]}}, rbyte};
      c_func3 == 3'b001: ext = {{16{rhalf[15]}}, rhalf};
      c_func3 == 3'b100: ext = {24'd0, rbyte};
      c_func3 == 3'b101: ext = {16'd0, rhalf};
      default: ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    strb = 4'b1111;
    wdat = c_wdata;
    unique case (1'b1)
      c_func3[1:0] == 2'b00: begin
        strb = 4'b0001 << off;
        wdat = {4{c_wdata[7:0]}};
      end
      c_func3[1:0] == 2'b01: begin
        strb = off[1] ? 4'b1100 : 4'b0011;
        wdat = {2{c_wdata[15:0]}};
      end
      default: begin
        strb = 4'b1111;
        wdat = c_wdata;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      err_q <= E_OK;
      c_load <= 1'b0;
      c_func3 <= 3'd0;
      c_addr <= 32'd0;
      c_wdata <= 32'd0;
      c_rd <= 5'd0;
      rd_q <= 5'd0;
      data_q <= 32'd0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      err_q <= err_d;
      if (take) begin
        c_load <= bus.lsu_load;
        c_func3 <= bus.lsu_func3;
        c_addr <= bus.lsu_addr;
        c_wdata <= bus.lsu_wdata;
        c_rd <= bus.lsu_rd;
      end
      if (fin_early) begin
        rd_q <= bus.lsu_rd;
        data_q <= 32'd0;
      end else if (fin_bus) begin
        rd_q <= c_rd;
        data_q <= (rsp_ok && c_load) ? ext : 32'd0;
      end
    end
  end

  logic in_req;
  logic in_done;

  assign in_req = (state == REQ);
  assign in_done = (state == DONE);

  assign bus.lsu_busy = (state != IDLE);
  assign bus.lsu_done = in_done;
  assign bus.lsu_error = in_done ? err_q : E_OK;
  assign bus.load_we = in_done && c_load && (err_q == E_OK);
  assign bus.load_rd = rd_q;
  assign bus.load_data = data_q;

  assign bus.mem_req = in_req;
  assign bus.mem_we = in_req && !c_load;
  assign bus.mem_addr = in_req ? {c_addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_wstrb = (in_req && !c_load) ? strb : 4'b0000;
  assign bus.mem_wdata = (in_req && !c_load) ? wdat : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a cycle-level
// memory responder and hand-computed expectations.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int n_vec;
  int n_bad;

  load_store_unit_if bus ();

  load_store_unit #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          o_lat;
  logic [1:0]  o_err;
  logic        o_we;
  logic [4:0]  o_rd;
  logic [31:0] o_data;
  logic        o_req;
  logic [31:0] o_maddr;
  logic        o_mwe;
  logic [3:0]  o_strb;
  logic [31:0] o_wd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic ld,
                      input logic [2:0] f3,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [4:0] rd,
                      input int rdy_dly,
                      input int rsp_dly,
                      input logic [31:0] rdata);
    int cyc;
    int rq;
    int wt;
    bit acc;
    bit rdy_prev;
    bit fin;
    cyc = 0;
    rq = 0;
    wt = 0;
    acc = 0;
    rdy_prev = 0;
    fin = 0;
    o_req = 0;
    o_maddr = 'x;
    o_mwe = 'x;
    o_strb = 'x;
    o_wd = 'x;
    @(negedge clk);
    bus.lsu_valid = 1'b1;
    bus.lsu_load = ld;
    bus.lsu_func3 = f3;
    bus.lsu_addr = addr;
    bus.lsu_wdata = wdata;
    bus.lsu_rd = rd;
    while (!fin && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.lsu_valid = 1'b0;
      if (rdy_prev) acc = 1;
      rdy_prev = 0;
      if (bus.lsu_done) begin
        fin = 1;
        o_lat = cyc;
        o_err = bus.lsu_error;
        o_we = bus.load_we;
        o_rd = bus.load_rd;
        o_data = bus.load_data;
        bus.mem_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
      end else begin
        if (bus.mem_req) begin
          if (rq == 0) begin
            o_maddr = bus.mem_addr;
            o_mwe = bus.mem_we;
            o_strb = bus.mem_wstrb;
            o_wd = bus.mem_wdata;
          end
          o_req = 1;
          bus.mem_ready = (rdy_dly >= 0 && rq >= rdy_dly);
          rdy_prev = bus.mem_ready;
          rq++;
        end else begin
          bus.mem_ready = 1'b0;
        end
        if (acc) begin
          bus.mem_rsp_valid = (rsp_dly >= 0 && wt >= rsp_dly);
          bus.mem_rdata = rdata;
          wt++;
        end
      end
    end
    chk("xact_bound", 32'(fin), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", 32'(bus.lsu_done), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.lsu_load = 1'b0;
    bus.lsu_func3 = 3'd0;
    bus.lsu_addr = 32'd0;
    bus.lsu_wdata = 32'd0;
    bus.lsu_rd = 5'd0;
    bus.mem_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata = 32'd0;
    #1;
    chk("rst_busy", 32'(bus.lsu_busy), 32'd0);
    chk("rst_done", 32'(bus.lsu_done), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mwe", 32'(bus.mem_we), 32'd0);
    chk("rst_data", bus.load_data, 32'd0);
    chk("rst_rd", 32'(bus.load_rd), 32'd0);
    chk("rst_err", 32'(bus.lsu_error), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // SW 0x100
    xact(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 0, 0, 32'h0);
    chk("sw_addr", o_maddr, 32'h100);
    chk("sw_strb", 32'(o_strb), 32'hF);
    chk("sw_wd", o_wd, 32'hDEADBEEF);
    chk("sw_we", 32'(o_mwe), 32'd1);
    chk("sw_lat", 32'(o_lat), 32'd3);
    chk("sw_err", 32'(o_err), 32'd0);
    chk("sw_lwe", 32'(o_we), 32'd0);

    // LB 0x103
    xact(1'b1, 3'b000, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF0000);
    chk("lb_data", o_data, 32'hFFFFFF80);
    chk("lb_lwe", 32'(o_we), 32'd1);
    chk("lb_rd", 32'(o_rd), 32'd5);
    chk("lb_strb", 32'(o_strb), 32'h0);
    chk("lb_addr", o_maddr, 32'h100);
    chk("lb_mwe", 32'(o_mwe), 32'd0);
    chk("lb_lat", 32'(o_lat), 32'd3);
    chk("lb_hold", bus.load_data, 32'hFFFFFF80);

    // LBU 0x103
    xact(1'b1, 3'b100, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80FF0000);
    chk("lbu_data", o_data, 32'h00000080);
    chk("lbu_rd", 32'(o_rd), 32'd6);

    // LHU 0x102
    xact(1'b1, 3'b101, 32'h102, 32'h0, 5'd7, 0, 0, 32'hBEEF1234);
    chk("lhu_data", o_data, 32'h0000BEEF);

    // LH 0x104 with bus delays
    xact(1'b1, 3'b001, 32'h104, 32'h0, 5'd8, 2, 1, 32'h1234F00D);
    chk("lh_data", o_data, 32'hFFFFF00D);
    chk("lh_lat", 32'(o_lat), 32'd6);
    chk("lh_addr", o_maddr, 32'h104);

    // LW passthrough
    xact(1'b1, 3'b010, 32'h10, 32'h0, 5'd9, 0, 0, 32'h89ABCDEF);
    chk("lw_data", o_data, 32'h89ABCDEF);

    // SH 0x102
    xact(1'b0, 3'b001, 32'h102, 32'h0000A5A5, 5'd0, 0, 0, 32'h0);
    chk("sh_strb", 32'(o_strb), 32'hC);
    chk("sh_wd", o_wd, 32'hA5A5A5A5);

    // SB 0x101
    xact(1'b0, 3'b000, 32'h101, 32'h00000077, 5'd0, 0, 0, 32'h0);
    chk("sb_strb", 32'(o_strb), 32'h2);
    chk("sb_wd", o_wd, 32'h77777777);

    // SH misaligned
    xact(1'b0, 3'b001, 32'h101, 32'h1234, 5'd0, 0, 0, 32'h0);
    chk("mis_err", 32'(o_err), 32'd1);
    chk("mis_lat", 32'(o_lat), 32'd1);
    chk("mis_req", 32'(o_req), 32'd0);

    // illegal load func3
    xact(1'b1, 3'b011, 32'h100, 32'h0, 5'd3, 0, 0, 32'h0);
    chk("f3_err", 32'(o_err), 32'd2);
    chk("f3_lwe", 32'(o_we), 32'd0);
    chk("f3_req", 32'(o_req), 32'd0);

    // illegal and misaligned together
    xact(1'b0, 3'b110, 32'h103, 32'h0, 5'd0, 0, 0, 32'h0);
    chk("prec_err", 32'(o_err), 32'd2);

    // timeout in REQ
    xact(1'b1, 3'b010, 32'h40, 32'h0, 5'd4, -1, -1, 32'h0);
    chk("to_err", 32'(o_err), 32'd3);
    chk("to_lat", 32'(o_lat), 32'd9);
    chk("to_lwe", 32'(o_we), 32'd0);

    // response on the final timeout cycle
    xact(1'b1, 3'b010, 32'h44, 32'h0, 5'd11, 6, 0, 32'hCAFEF00D);
    chk("coin_err", 32'(o_err), 32'd0);
    chk("coin_lat", 32'(o_lat), 32'd9);
    chk("coin_data", o_data, 32'hCAFEF00D);
    chk("coin_lwe", 32'(o_we), 32'd1);

    // timeout in WAIT, then a late response
    xact(1'b1, 3'b010, 32'h48, 32'h0, 5'd12, 0, -1, 32'h0);
    chk("tow_err", 32'(o_err), 32'd3);
    chk("tow_lat", 32'(o_lat), 32'd9);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("late_done", 32'(bus.lsu_done), 32'd0);
    end
    bus.mem_rsp_valid = 1'b0;
    chk("late_busy", 32'(bus.lsu_busy), 32'd0);

    // reset during WAIT
    @(negedge clk);
    bus.lsu_valid = 1'b1;
    bus.lsu_load = 1'b1;
    bus.lsu_func3 = 3'b010;
    bus.lsu_addr = 32'h200;
    bus.lsu_rd = 5'd13;
    @(posedge clk);
    @(negedge clk);
    bus.lsu_valid = 1'b0;
    chk("wr_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("wr_busy", 32'(bus.lsu_busy), 32'd1);
    chk("wr_wreq", 32'(bus.mem_req), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(bus.mem_req), 32'd0);
    chk("ar_busy", 32'(bus.lsu_busy), 32'd0);
    chk("ar_done", 32'(bus.lsu_done), 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata = 32'h22222222;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ar_rsp", 32'(bus.lsu_done), 32'd0);
    end
    bus.mem_rsp_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ar_post", 32'(bus.lsu_busy), 32'd0);
    chk("ar_data", bus.load_data, 32'd0);

    // normal LW after reset
    xact(1'b1, 3'b010, 32'h204, 32'h0, 5'd14, 0, 0, 32'h5A5AA5A5);
    chk("pr_data", o_data, 32'h5A5AA5A5);
    chk("pr_err", 32'(o_err), 32'd0);
    chk("pr_lat", 32'(o_lat), 32'd3);
    chk("pr_rd", 32'(o_rd), 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
